// File: rtl/change_dispenser_if.sv
// change_dispenser_if
//   Bundles the credit inputs, the vend/refund requests, the product and
//   coin valid/ack handshakes and the status outputs of change_dispenser.
//   slave  : the dispenser controller (drives handshake valids and status)
//   master : the credit register / mechanism side (drives credit and acks)
//   Optional macro: CHANGE_REFUND_EN adds the refund_req signal.
interface change_dispenser_if;
  logic       state0, state1, state2, state3, state4, state5, state6;
  logic       vend_req;
  logic       prod_valid;
  logic       prod_ack;
  logic       coin_valid;
  logic       coin_ack;
  logic [2:0] coins_left;
  logic       clear_credit;
  logic       insufficient;
  logic       busy;
  logic       fault;
`ifdef CHANGE_REFUND_EN
  logic       refund_req;

  modport slave (
    input  state0, state1, state2, state3, state4, state5, state6,
    input  vend_req, prod_ack, coin_ack, refund_req,
    output prod_valid, coin_valid, coins_left, clear_credit,
    output insufficient, busy, fault
  );

  modport master (
    output state0, state1, state2, state3, state4, state5, state6,
    output vend_req, prod_ack, coin_ack, refund_req,
    input  prod_valid, coin_valid, coins_left, clear_credit,
    input  insufficient, busy, fault
  );
`else
  modport slave (
    input  state0, state1, state2, state3, state4, state5, state6,
    input  vend_req, prod_ack, coin_ack,
    output prod_valid, coin_valid, coins_left, clear_credit,
    output insufficient, busy, fault
  );

  modport master (
    output state0, state1, state2, state3, state4, state5, state6,
    output vend_req, prod_ack, coin_ack,
    input  prod_valid, coin_valid, coins_left, clear_credit,
    input  insufficient, busy, fault
  );
`endif
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser
//   Reader side of the vending credit register. It samples the one-hot credit
//   when a vend is requested, releases the product, returns change one quarter
//   per coin handshake and then pulses clear_credit to return the credit
//   register to S0.
//   Ports:
//     CLK  - system clock, all flops update on the falling edge
//     RES  - asynchronous active-low reset
//     bus  - change_dispenser_if.slave: state0..6, vend_req, prod_valid/ack,
//            coin_valid/ack, coins_left, clear_credit, insufficient, busy,
//            fault (and refund_req when CHANGE_REFUND_EN is defined)
//   Parameter PRICE_QUARTERS: product price in quarters, 1..6.
//   Optional macro CHANGE_REFUND_EN: refund path that returns all credit as
//   coins without releasing a product.
//
//   state  | meaning
//   IDLE   | waiting for vend_req (or refund_req)
//   VEND   | prod_valid high until prod_ack
//   CHANGE | coin_valid high, one quarter per coin_ack
//   DONE   | one-cycle clear_credit pulse
//   FAULT  | credit was not one-hot at sample time; left only by reset
module change_dispenser #(
  parameter int PRICE_QUARTERS = 4
) (
  input logic               CLK,
  input logic               RES,
  change_dispenser_if.slave bus
);

  localparam logic [2:0] PRICE_Q = 3'(PRICE_QUARTERS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VEND   = 3'd1,
    CHANGE = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t     state;
  logic [6:0] credit;
  logic [2:0] q;
  logic       credit_ok;

  assign credit = {bus.state6, bus.state5, bus.state4, bus.state3,
                   bus.state2, bus.state1, bus.state0};

  assign credit_ok = $onehot(credit);

  // q is only meaningful when credit_ok is set.
  always_comb begin
    q = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (credit[i]) q = 3'(i);
    end
  end

  always_ff @(negedge CLK or negedge RES) begin
    if (!RES) begin
      state            <= IDLE;
      bus.coins_left   <= 3'd0;
      bus.prod_valid   <= 1'b0;
      bus.coin_valid   <= 1'b0;
      bus.clear_credit <= 1'b0;
      bus.insufficient <= 1'b0;
      bus.busy         <= 1'b0;
      bus.fault        <= 1'b0;
    end else begin
      bus.insufficient <= 1'b0;
      bus.clear_credit <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.vend_req) begin
            if (!credit_ok) begin
              state     <= FAULT;
              bus.fault <= 1'b1;
              bus.busy  <= 1'b1;
            end else if (q < PRICE_Q) begin
              bus.insufficient <= 1'b1;
            end else begin
              // change amount frozen here; later credit changes are ignored
              bus.coins_left <= q - PRICE_Q;
              bus.prod_valid <= 1'b1;
              bus.busy       <= 1'b1;
              state          <= VEND;
            end
          end
`ifdef CHANGE_REFUND_EN
          else if (bus.refund_req) begin
            if (!credit_ok) begin
              state     <= FAULT;
              bus.fault <= 1'b1;
              bus.busy  <= 1'b1;
            end else if (q == 3'd0) begin
              bus.clear_credit <= 1'b1;
              bus.busy         <= 1'b1;
              state            <= DONE;
            end else begin
              bus.coins_left <= q;
              bus.coin_valid <= 1'b1;
              bus.busy       <= 1'b1;
              state          <= CHANGE;
            end
          end
`endif
        end

        VEND: begin
          if (bus.prod_ack) begin
            bus.prod_valid <= 1'b0;
            if (bus.coins_left != 3'd0) begin
              bus.coin_valid <= 1'b1;
              state          <= CHANGE;
            end else begin
              bus.clear_credit <= 1'b1;
              state            <= DONE;
            end
          end
        end

        CHANGE: begin
          if (bus.coin_ack) begin
            bus.coins_left <= bus.coins_left - 3'd1;
            if (bus.coins_left == 3'd1) begin
              bus.coin_valid   <= 1'b0;
              bus.clear_credit <= 1'b1;
              state            <= DONE;
            end
          end
        end

        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        FAULT: begin
          bus.fault <= 1'b1;
          bus.busy  <= 1'b1;
        end

        default: begin
          state          <= IDLE;
          bus.coins_left <= 3'd0;
          bus.prod_valid <= 1'b0;
          bus.coin_valid <= 1'b0;
          bus.busy       <= 1'b0;
          bus.fault      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  localparam int PRICE = 4;

  logic CLK;
  logic RES;
  int   checks;
  int   errors;

  change_dispenser_if dif ();

  change_dispenser #(.PRICE_QUARTERS(PRICE)) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (dif.slave)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0] credit;
    int         pdelay;
    bit         exp_fault;
    bit         exp_insuff;
    int         exp_coins;
  } vec_t;

  task automatic tick();
    @(posedge CLK);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_credit(input logic [6:0] cr);
    dif.state0 = cr[0];
    dif.state1 = cr[1];
    dif.state2 = cr[2];
    dif.state3 = cr[3];
    dif.state4 = cr[4];
    dif.state5 = cr[5];
    dif.state6 = cr[6];
  endtask

  // Coin phase: owed quarters remain, FSM is in CHANGE, then DONE, then IDLE.
  task automatic coin_phase(input int owed_in);
    int owed;
    int guard;
    owed  = owed_in;
    guard = 0;
    while (owed > 0 && guard < 100) begin
      chk("coin_valid_high", int'(dif.coin_valid), 1);
      chk("coins_left", int'(dif.coins_left), owed);
      chk("prod_valid_low", int'(dif.prod_valid), 0);
      dif.coin_ack = ($urandom_range(0, 2) != 0);
      dif.prod_ack = 1'($urandom_range(0, 1));
      tick();
      if (dif.coin_ack) owed--;
      guard++;
    end
    dif.coin_ack = 1'b0;
    dif.prod_ack = 1'b0;
    chk("coin_budget", owed, 0);
    chk("coin_valid_low_done", int'(dif.coin_valid), 0);
    chk("clear_credit_pulse", int'(dif.clear_credit), 1);
    chk("coins_left_zero", int'(dif.coins_left), 0);
    tick();
    chk("clear_credit_end", int'(dif.clear_credit), 0);
    chk("busy_end", int'(dif.busy), 0);
  endtask

  // Called one cycle after sampling, with FSM in VEND.
  task automatic finish_vend(input int pdelay, input int coins);
    int pv_cycles;
    pv_cycles = 1;
    set_credit(7'($urandom));  // credit changes after sampling are ignored
    for (int i = 0; i < pdelay; i++) begin
      dif.coin_ack = 1'($urandom_range(0, 1));
      tick();
      if (dif.prod_valid) pv_cycles++;
    end
    chk("prod_valid_cycles", pv_cycles, pdelay + 1);
    dif.coin_ack = 1'b0;
    dif.prod_ack = 1'b1;
    tick();
    dif.prod_ack = 1'b0;
    chk("prod_valid_drop", int'(dif.prod_valid), 0);
    chk("busy_after_ack", int'(dif.busy), 1);
    if (coins == 0) begin
      chk("coin_valid_never", int'(dif.coin_valid), 0);
      chk("clear_after_ack", int'(dif.clear_credit), 1);
      tick();
      chk("clear_credit_end", int'(dif.clear_credit), 0);
      chk("busy_end", int'(dif.busy), 0);
    end else begin
      coin_phase(coins);
    end
  endtask

  task automatic do_reset();
    RES = 1'b0;
    #1;
    chk("rst_fault", int'(dif.fault), 0);
    chk("rst_busy", int'(dif.busy), 0);
    chk("rst_prod_valid", int'(dif.prod_valid), 0);
    chk("rst_coin_valid", int'(dif.coin_valid), 0);
    chk("rst_coins_left", int'(dif.coins_left), 0);
    chk("rst_clear", int'(dif.clear_credit), 0);
    chk("rst_insuff", int'(dif.insufficient), 0);
    @(posedge CLK);
    RES = 1'b1;
    tick();
  endtask

  task automatic run_vend(input vec_t v);
    set_credit(v.credit);
    dif.vend_req = 1'b1;
    tick();
    dif.vend_req = 1'b0;
    if (v.exp_fault) begin
      chk("fault_set", int'(dif.fault), 1);
      chk("fault_busy", int'(dif.busy), 1);
      chk("fault_prod_valid", int'(dif.prod_valid), 0);
      for (int i = 0; i < 3; i++) begin
        dif.vend_req = 1'($urandom_range(0, 1));
        set_credit(7'b0010000);
        tick();
      end
      dif.vend_req = 1'b0;
      chk("fault_sticky", int'(dif.fault), 1);
      chk("fault_handshake", int'(dif.prod_valid) + int'(dif.coin_valid) + int'(dif.clear_credit), 0);
      do_reset();
    end else if (v.exp_insuff) begin
      chk("insuff_pulse", int'(dif.insufficient), 1);
      chk("insuff_busy", int'(dif.busy), 0);
      chk("insuff_prod_valid", int'(dif.prod_valid), 0);
      tick();
      chk("insuff_end", int'(dif.insufficient), 0);
      chk("insuff_busy2", int'(dif.busy), 0);
      chk("insuff_prod_valid2", int'(dif.prod_valid), 0);
    end else begin
      chk("vend_prod_valid", int'(dif.prod_valid), 1);
      chk("vend_busy", int'(dif.busy), 1);
      chk("vend_insuff", int'(dif.insufficient), 0);
      chk("vend_coins_left", int'(dif.coins_left), v.exp_coins);
      finish_vend(v.pdelay, v.exp_coins);
    end
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    checks = 0;
    errors = 0;
    RES = 1'b1;
    set_credit(7'b0);
    dif.vend_req = 1'b0;
    dif.prod_ack = 1'b0;
    dif.coin_ack = 1'b0;
`ifdef CHANGE_REFUND_EN
    dif.refund_req = 1'b0;
`endif
    #2;
    do_reset();

    // Directed table: credit, prod_ack delay, fault, insufficient, coins owed.
    vecs.push_back('{7'b1000000, 2, 1'b0, 1'b0, 2});
    vecs.push_back('{7'b0010000, 0, 1'b0, 1'b0, 0});
    vecs.push_back('{7'b0000100, 0, 1'b0, 1'b1, 0});
    vecs.push_back('{7'b0001010, 0, 1'b1, 1'b0, 0});
    vecs.push_back('{7'b0100000, 1, 1'b0, 1'b0, 1});
    vecs.push_back('{7'b0000001, 0, 1'b0, 1'b1, 0});
    vecs.push_back('{7'b0000000, 0, 1'b1, 1'b0, 0});
    vecs.push_back('{7'b0001000, 0, 1'b0, 1'b1, 0});
    vecs.push_back('{7'b1000000, 0, 1'b0, 1'b0, 2});
    vecs.push_back('{7'b1111111, 0, 1'b1, 1'b0, 0});
    foreach (vecs[i]) run_vend(vecs[i]);

    // Reset in CHANGE with coin_ack held high: abort, no clear pulse.
    set_credit(7'b0100000);
    dif.vend_req = 1'b1;
    tick();
    dif.vend_req = 1'b0;
    chk("midrst_coins", int'(dif.coins_left), 1);
    dif.prod_ack = 1'b1;
    dif.coin_ack = 1'b1;
    tick();
    dif.prod_ack = 1'b0;
    chk("midrst_in_change", int'(dif.coin_valid), 1);
    RES = 1'b0;
    #1;
    chk("midrst_coin_valid", int'(dif.coin_valid), 0);
    chk("midrst_coins_left", int'(dif.coins_left), 0);
    chk("midrst_busy", int'(dif.busy), 0);
    tick();
    tick();
    RES = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_clear", int'(dif.clear_credit), 0);
      chk("midrst_no_coin", int'(dif.coin_valid), 0);
      chk("midrst_idle", int'(dif.busy), 0);
    end
    dif.coin_ack = 1'b0;

`ifdef CHANGE_REFUND_EN
    // Refund of S3: three coins, no product.
    set_credit(7'b0001000);
    dif.refund_req = 1'b1;
    tick();
    dif.refund_req = 1'b0;
    chk("refund_no_prod", int'(dif.prod_valid), 0);
    chk("refund_busy", int'(dif.busy), 1);
    coin_phase(3);
    // Refund of S0: straight to DONE.
    set_credit(7'b0000001);
    dif.refund_req = 1'b1;
    tick();
    dif.refund_req = 1'b0;
    chk("refund0_clear", int'(dif.clear_credit), 1);
    chk("refund0_no_coin", int'(dif.coin_valid), 0);
    tick();
    chk("refund0_idle", int'(dif.busy), 0);
    // vend_req wins over refund_req.
    set_credit(7'b1000000);
    dif.vend_req   = 1'b1;
    dif.refund_req = 1'b1;
    tick();
    dif.vend_req   = 1'b0;
    dif.refund_req = 1'b0;
    chk("prio_prod_valid", int'(dif.prod_valid), 1);
    chk("prio_coins_left", int'(dif.coins_left), 6 - PRICE);
    finish_vend(1, 6 - PRICE);
`endif

    // Randomized transactions against an arithmetic credit model.
    for (int n = 0; n < 40; n++) begin
      int qi;
      if ($urandom_range(0, 9) < 8) begin
        qi = $urandom_range(0, 6);
        rv.credit = 7'(1 << qi);
      end else begin
        rv.credit = 7'($urandom);
      end
      rv.pdelay    = $urandom_range(0, 3);
      rv.exp_fault = ($countones(rv.credit) != 1);
      qi = 0;
      for (int b = 0; b < 7; b++) if (rv.credit[b]) qi = b;
      rv.exp_insuff = !rv.exp_fault && (qi < PRICE);
      rv.exp_coins  = (rv.exp_fault || rv.exp_insuff) ? 0 : qi - PRICE;
      run_vend(rv);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Reader side of the vending credit register. It samples the one-hot credit bits (S0 = $0.00 through S6 = $1.50, in $0.25 steps) when a vend is requested. It then dispenses the product and returns the change one quarter at a time over valid/ack handshakes. It ends with a one-cycle pulse that clears the credit register back to S0.

Parameters:
PRICE_QUARTERS, 4, product price in quarters; legal range 1..6 (default = $1.00)

Ports:
CLK  input  1  system clock; all flops update on the falling edge of CLK
RES  input  1  asynchronous, active-low reset
state0..state6  input  1 each  one-hot credit from the credit register; stateN = N quarters
vend_req  input  1  level request to vend; sampled only in IDLE
prod_valid  output  1  product-release request to the dispenser mechanism
prod_ack  input  1  mechanism accepted the product release
coin_valid  output  1  request to eject one quarter
coin_ack  input  1  coin ejector accepted one quarter
coins_left  output  3  quarters still owed (unsigned)
clear_credit  output  1  one-cycle pulse; credit next-state logic forces S0
insufficient  output  1  one-cycle pulse; vend_req with credit below price
busy  output  1  high in any state except IDLE
fault  output  1  credit bits not exactly one-hot at sample time; sticky
refund_req  input  1  present only with CHANGE_REFUND_EN

Behaviour:
- Reset (RES=0, asynchronous): state=IDLE, coins_left=0. prod_valid, coin_valid, clear_credit, insufficient, busy and fault are all 0. Reset mid-handshake aborts the operation: no clear_credit pulse, no further coin.
- Decode: q = index of the single asserted stateN (0..6). Zero or multiple bits asserted means invalid.
- IDLE:
  - vend_req=1 with invalid credit: go to FAULT.
  - vend_req=1 with q < PRICE_QUARTERS: insufficient=1 for exactly one cycle; stay in IDLE.
  - vend_req=1 with q >= PRICE_QUARTERS: coins_left <= q - PRICE_QUARTERS; go to VEND.
- VEND:
  - prod_valid=1, held until a falling edge with prod_ack=1.
  - On that edge: go to CHANGE if coins_left != 0, else go to DONE.
- CHANGE:
  - coin_valid=1 continuously.
  - Each edge with coin_ack=1 decrements coins_left by 1.
  - The ack that takes coins_left from 1 to 0 moves the FSM to DONE, with coin_valid low from the next cycle.
  - Back-to-back acks are legal: one coin per cycle.
- DONE: clear_credit=1 for exactly one cycle, then IDLE.
- FAULT: fault=1; all handshake outputs 0; busy=1. Exit only via reset.
- Ignored inputs:
  - prod_ack outside VEND and coin_ack outside CHANGE.
  - vend_req while busy.
  - Credit input changes after sampling; the change amount is frozen at sample time.
- Output timing: all outputs are registered or decoded from state only; there is no combinational path from input to output.
- Latency:
  - vend_req to prod_valid: 1 cycle.
  - Final ack to clear_credit: 1 cycle.
  - clear_credit to IDLE: 1 cycle.
- Width: coins_left never underflows; the maximum value is 6 - PRICE_QUARTERS, which is at most 5.

Optional Feature:
CHANGE_REFUND_EN
- Defined:
  - refund_req port exists.
  - In IDLE, refund_req=1 with valid credit sets coins_left <= q and goes straight to CHANGE; no product is released.
  - If q=0, it goes directly to DONE.
  - Invalid credit goes to FAULT.
  - If vend_req and refund_req are both high, vend_req has priority.
- Undefined: no refund_req port and no refund path; behaviour is otherwise identical.

Test Plan:
- PRICE=4, credit S6, vend_req pulse, prod_ack after 2 cycles -> prod_valid for 3 cycles; coins_left=2; two coin acks -> coins_left 2,1,0; clear_credit one cycle; back to IDLE.
- PRICE=4, credit S4, vend_req, prod_ack -> coin_valid never asserts; clear_credit the cycle after the ack.
- PRICE=4, credit S2, vend_req -> insufficient one-cycle pulse; prod_valid stays 0; busy stays 0.
- state1 and state3 both high, vend_req -> fault=1 held; reset releases it to IDLE with all outputs 0.
- Credit S5, in CHANGE with coin_ack held high, assert RES low mid-stream -> coin_valid drops immediately, coins_left=0, no clear_credit pulse.
- CHANGE_REFUND_EN defined, credit S3, refund_req -> no prod_valid; 3 coins ejected; then clear_credit.
